// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA1 job dispatcher: FSM state encoding,
// message block width and the channel-number type.
package sha1_pkg;

    localparam int SHA1_BLOCK_W           = 512;
    localparam int SHA1_CHANNEL_NUM_TOTAL = 64;
    localparam int SHA1_CHANNEL_NUM_WIDTH = $clog2(SHA1_CHANNEL_NUM_TOTAL);

    typedef logic [SHA1_CHANNEL_NUM_WIDTH-1:0] chan_num_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALLOC,
        ST_SEND
    } state_t;

endpackage

// File: rtl/sha1_dispatch_outreg.sv
// Valid/ready output stage: holds one block with its channel tag and
// first/last markers stable until the core array takes it.
module sha1_dispatch_outreg #(
    parameter int DATA_WIDTH = 512,
    parameter int CHAN_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [CHAN_WIDTH-1:0] load_chan,
    input  logic                  load_first,
    input  logic                  load_last,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CHAN_WIDTH-1:0] out_chan,
    output logic                  out_first,
    output logic                  out_last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_chan  <= load_chan;
            out_first <= load_first;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sha1_job_dispatch.sv
// Message dispatcher: pops one free channel per message, tags every block of the
// message with it, and tracks allocated channels. SHA1_DISPATCH_STATS_EN adds counters.
module sha1_job_dispatch
    import sha1_pkg::*;
#(
    parameter int CHANNEL_NUM_TOTAL = SHA1_CHANNEL_NUM_TOTAL,
    parameter int CHANNEL_NUM_WIDTH = $clog2(CHANNEL_NUM_TOTAL),
    parameter int DATA_WIDTH        = SHA1_BLOCK_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic                         chan_fifo_empty,
    input  logic [CHANNEL_NUM_WIDTH-1:0] chan_fifo_dout,
    output logic                         chan_fifo_rd_ena,
    input  logic                         chan_release,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CHANNEL_NUM_WIDTH-1:0] out_chan,
    output logic                         out_first,
    output logic                         out_last,
    output logic [CHANNEL_NUM_WIDTH:0]   outstanding,
    output logic                         proto_err
`ifdef SHA1_DISPATCH_STATS_EN
    ,
    output logic [31:0]                  stat_msg_cnt,
    output logic [31:0]                  stat_stall_cnt
`endif
);

    localparam logic [CHANNEL_NUM_WIDTH:0] OUT_MAX = CHANNEL_NUM_TOTAL[CHANNEL_NUM_WIDTH:0];

    state_t                         state_reg, state_next;
    logic [CHANNEL_NUM_WIDTH-1:0]   cur_chan_reg;
    logic                           first_pend_reg;
    logic [CHANNEL_NUM_WIDTH:0]     outstanding_reg, outstanding_next;
    logic                           proto_err_reg;
    logic                           accept;
    logic                           fsm_err;
    logic                           cnt_err;
    logic                           send_ready;

    assign send_ready = !out_valid || out_ready;

    // Combinational outputs are forced idle while rst is high so nothing pops during reset.
    always_comb begin
        state_next       = state_reg;
        in_ready         = 1'b0;
        chan_fifo_rd_ena = 1'b0;
        accept           = 1'b0;
        fsm_err          = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid && !in_first) begin
                        in_ready = 1'b1;
                        fsm_err  = 1'b1;
                    end else if (in_valid) begin
                        state_next = ST_ALLOC;
                    end
                end
                ST_ALLOC: begin
                    if (!chan_fifo_empty) begin
                        chan_fifo_rd_ena = 1'b1;
                        state_next       = ST_SEND;
                    end
                end
                ST_SEND: begin
                    in_ready = send_ready;
                    accept   = in_valid && send_ready;
                    fsm_err  = accept && in_first && !first_pend_reg;
                    if (accept && in_last) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Pop and release in the same cycle cancel; underflow and overflow saturate and flag.
    always_comb begin
        outstanding_next = outstanding_reg;
        cnt_err          = 1'b0;
        if (chan_fifo_rd_ena && !chan_release) begin
            if (outstanding_reg == OUT_MAX) begin
                cnt_err = 1'b1;
            end else begin
                outstanding_next = outstanding_reg + 1'b1;
            end
        end else if (!chan_fifo_rd_ena && chan_release) begin
            if (outstanding_reg == '0) begin
                cnt_err = 1'b1;
            end else begin
                outstanding_next = outstanding_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            cur_chan_reg    <= '0;
            first_pend_reg  <= 1'b0;
            outstanding_reg <= '0;
            proto_err_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            outstanding_reg <= outstanding_next;
            if (chan_fifo_rd_ena) begin
                cur_chan_reg   <= chan_fifo_dout;
                first_pend_reg <= 1'b1;
            end else if (accept) begin
                first_pend_reg <= 1'b0;
            end
            if (fsm_err || cnt_err) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

    assign outstanding = outstanding_reg;
    assign proto_err   = proto_err_reg;

    sha1_dispatch_outreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .CHAN_WIDTH (CHANNEL_NUM_WIDTH)
    ) u_outreg (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_data  (in_data),
        .load_chan  (cur_chan_reg),
        .load_first (first_pend_reg),
        .load_last  (in_last),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_first  (out_first),
        .out_last   (out_last)
    );

`ifdef SHA1_DISPATCH_STATS_EN
    logic [31:0] stat_msg_cnt_reg;
    logic [31:0] stat_stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_msg_cnt_reg   <= '0;
            stat_stall_cnt_reg <= '0;
        end else begin
            if (chan_fifo_rd_ena) begin
                stat_msg_cnt_reg <= stat_msg_cnt_reg + 32'd1;
            end
            if (state_reg == ST_ALLOC && chan_fifo_empty) begin
                stat_stall_cnt_reg <= stat_stall_cnt_reg + 32'd1;
            end
        end
    end

    assign stat_msg_cnt   = stat_msg_cnt_reg;
    assign stat_stall_cnt = stat_stall_cnt_reg;
`endif

endmodule

// File: doc/sha1_job_dispatch.md
Name: sha1_job_dispatch

Overview:
- Front-end dispatcher that sits directly upstream of the SHA1 channel array and consumes free channel numbers from the channel-control FWFT free-list FIFO.
- For each incoming message it pops one free channel, holds that channel for every 512-bit block of the message, and forwards the blocks tagged with the channel to the hash cores.
- It tracks how many channels are outstanding, using the same release pulse that returns a channel number to the free list.

Parameters:
- CHANNEL_NUM_TOTAL, 64, number of hash channels (power of two).
- CHANNEL_NUM_WIDTH, $clog2(CHANNEL_NUM_TOTAL), channel-number width.
- DATA_WIDTH, 512, message block width.

Ports:
- clk  input  1  sole clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream block valid.
- in_ready  output  1  upstream block accepted when in_valid & in_ready.
- in_data  input  DATA_WIDTH  message block.
- in_first  input  1  first block of a message.
- in_last  input  1  last block of a message (in_first & in_last = single-block message).
- chan_fifo_empty  input  1  free-list FIFO empty.
- chan_fifo_dout  input  CHANNEL_NUM_WIDTH  free-list head, FWFT, valid when !empty.
- chan_fifo_rd_ena  output  1  pops the free-list head.
- chan_release  input  1  one-cycle pulse: a channel finished (same signal as the free-list write-back valid).
- out_valid  output  1  block to cores valid.
- out_ready  input  1  core array accepts.
- out_data  output  DATA_WIDTH  registered block.
- out_chan  output  CHANNEL_NUM_WIDTH  channel tag.
- out_first  output  1  first block for out_chan.
- out_last  output  1  last block for out_chan.
- outstanding  output  CHANNEL_NUM_WIDTH+1  channels currently allocated.
- proto_err  output  1  sticky protocol error.

Behaviour:
- Reset (synchronous, rst=1): state=ST_IDLE, out_valid=0, out_data/out_chan/out_first/out_last=0, outstanding=0, proto_err=0, chan_fifo_rd_ena=0. The free-list owner must be reset in the same cycle; a mid-operation reset discards the in-flight message and its channel.
- State machine:
  - ST_IDLE:
    - in_ready=0, except when in_valid & !in_first. In that case in_ready=1, the block is dropped, proto_err is set, and the state stays ST_IDLE.
    - in_valid & in_first -> ST_ALLOC.
  - ST_ALLOC:
    - in_ready=0.
    - chan_fifo_rd_ena = !chan_fifo_empty (combinational, one cycle). In the same cycle cur_chan<=chan_fifo_dout, first_pend<=1, outstanding+1, then -> ST_SEND.
    - If the FIFO is empty, wait indefinitely.
  - ST_SEND:
    - in_ready = !out_valid | out_ready.
    - On accept: out_data<=in_data, out_chan<=cur_chan, out_first<=first_pend, out_last<=in_last, out_valid<=1, first_pend<=0.
    - An accepted block with in_last -> ST_IDLE.
    - An accepted block with in_first other than the pending first block sets proto_err; the block is still forwarded.
- Output register: out_valid clears on out_ready when no new accept occurs in the same cycle. Output fields hold stable while out_valid & !out_ready.
- Latency: ST_IDLE->ST_ALLOC is 1 cycle, ST_ALLOC->ST_SEND is at least 1 cycle, and accept-to-out_valid is 1 cycle. With a non-empty FIFO and out_ready=1, the first block appears 3 cycles after in_valid rises. Throughput afterwards is 1 block/cycle.
- The pop occurs only in ST_ALLOC; chan_fifo_rd_ena is never asserted while empty.
- outstanding counter:
  - +1 on pop, -1 on chan_release; both in the same cycle leaves it unchanged.
  - chan_release with outstanding==0: hold at 0 and set proto_err.
  - Never exceeds CHANNEL_NUM_TOTAL. A pop when outstanding==CHANNEL_NUM_TOTAL cannot occur while the FIFO is consistent; if it does, saturate and set proto_err.
- proto_err clears only on rst.

Optional Feature:
- Macro SHA1_DISPATCH_STATS_EN.
- Defined: adds outputs stat_msg_cnt[31:0] (increments per pop) and stat_stall_cnt[31:0] (increments each cycle in ST_ALLOC with chan_fifo_empty=1). Both counters wrap at 2^32 and reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package sha1_pkg: state enum (ST_IDLE, ST_ALLOC, ST_SEND), SHA1_BLOCK_W=512, and a channel-number typedef derived from CHANNEL_NUM_TOTAL.
- One natural sub-module, sha1_dispatch_outreg: valid/ready output register carrying data, chan, first and last.
- Counter and FSM stay in the top module.

Test Plan:
- FIFO pre-loaded with 0..63; one 1-block message (first=last=1), out_ready=1.
  - chan_fifo_rd_ena pulses once; out_chan=0, out_first=1, out_last=1 three cycles after in_valid; outstanding=1.
- 3-block message.
  - One pop only; three beats all out_chan=0, out_first only on beat 0, out_last only on beat 2.
  - Next message gets out_chan=1; outstanding=2.
- FIFO empty for 10 cycles while in ST_ALLOC.
  - in_ready=0 and no pop; stat_stall_cnt=10 (with SHA1_DISPATCH_STATS_EN).
  - Then the FIFO supplies 5 -> out_chan=5.
- out_ready held low 4 cycles mid-message.
  - out_data/out_chan stable, in_ready=0, no block lost or duplicated.
- chan_release coincident with a pop at outstanding=3.
  - outstanding stays 3.
  - chan_release at outstanding=0: stays 0, proto_err=1.
- in_valid with in_first=0 in ST_IDLE.
  - Block dropped, proto_err=1, no pop.
  - rst mid-message: all outputs return to reset values next cycle.
